// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Fully pipelined barrel shifter with five modes (SLL, SRL, SRA, ROL, ROR).
// The shift amount is resolved one bit per registered stage, MSB first, so
// stage 0 shifts by WIDTH/2 and the last stage shifts by 1. A valid/ready
// handshake with a single global advance enable provides full backpressure
// at one operation per cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high; discards all in-flight ops
//   in_valid   in   operation presented
//   in_ready   out  operation accepted this cycle (combinational on out_ready)
//   in_data    in   [WIDTH-1:0] operand
//   in_shamt   in   [SHW-1:0]   shift amount, 0..WIDTH-1
//   in_op      in   [2:0]       000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR,
//                               101..111 reserved (pass-through, err = 1)
//   out_valid  out  result valid (registered)
//   out_ready  in   consumer accepts result
//   out_data   out  [WIDTH-1:0] result (registered)
//   out_zero   out  out_data == 0 (combinational from out_data)
//   out_err    out  operation was reserved (registered)
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int LAT   = SHW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // One conditional shift/rotate by a fixed power-of-two amount. Reserved
    // ops fall through to the unshifted operand. SRA works per stage because
    // each stage preserves the sign bit, so the original sign is always the
    // current MSB.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       op,
        input logic             en,
        input int unsigned      amt
    );
        logic signed [WIDTH-1:0] sd;
        logic        [WIDTH-1:0] r;
        sd = $signed(d);
        r  = d;
        if (en) begin
            case (op)
                OP_SLL:  r = d << amt;
                OP_SRL:  r = d >> amt;
                OP_SRA:  r = sd >>> amt;
                OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
                OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_ROR;
    endfunction

    // Stage registers. op and the shift amount are not needed after the
    // last stage, so those arrays stop one short.
    logic             vld_p   [SHW];
    logic [WIDTH-1:0] data_p  [SHW];
    logic             err_p   [SHW];
    logic [2:0]       op_p    [SHW-1];
    logic [SHW-1:0]   shamt_p [SHW-1];

    logic advance;

    assign out_valid = vld_p[SHW-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_data  = data_p[SHW-1];
    assign out_err   = err_p[SHW-1];
    assign out_zero  = (out_data == '0);

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned AMT = 1 << (SHW - 1 - k);

        logic             vld_in;
        logic [WIDTH-1:0] data_in;
        logic [2:0]       op_in;
        logic [SHW-1:0]   shamt_in;
        logic             err_in;

        if (k == 0) begin : g_head
            assign vld_in   = in_valid;
            assign data_in  = in_data;
            assign op_in    = in_op;
            assign shamt_in = in_shamt;
            assign err_in   = is_reserved(in_op);
        end else begin : g_body
            assign vld_in   = vld_p[k-1];
            assign data_in  = data_p[k-1];
            assign op_in    = op_p[k-1];
            assign shamt_in = shamt_p[k-1];
            assign err_in   = err_p[k-1];
        end

        // ---- stage k: shift by 2^(SHW-1-k) under shamt bit SHW-1-k ----
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
                err_p[k]  <= 1'b0;
            end else if (advance) begin
                vld_p[k]  <= vld_in;
                data_p[k] <= stage_shift(data_in, op_in, shamt_in[SHW-1-k], AMT);
                err_p[k]  <= err_in;
            end
        end

        if (k < SHW - 1) begin : g_ctl
            always_ff @(posedge clock) begin
                if (advance) begin
                    op_p[k]    <= op_in;
                    shamt_p[k] <= shamt_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int LAT   = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_err;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   rx_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on every output transfer; also checks that
    // a stalled output is held stable into the next cycle.
    task automatic monitor();
        logic        held = 1'b0;
        logic [31:0] held_data = '0;
        logic        held_err = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (held) begin
                chk("stall_hold_data", out_data, held_data);
                chk("stall_hold_err", {31'b0, out_err}, {31'b0, held_err});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h, expected no output", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_zero", {31'b0, out_zero}, {31'b0, (e.data == 32'h0)});
                    chk("out_err", {31'b0, out_err}, {31'b0, e.err});
                    if (e.chk_lat)
                        chk("latency", cyc - e.acc, LAT - 1);
                end
                rx_count++;
            end
            held = out_valid && !out_ready && !reset;
            held_data = out_data;
            held_err = out_err;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input logic [31:0] exp, input logic exp_err, input bit chk_lat);
        int t = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        while (!done) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back('{exp, exp_err, cyc + 1, chk_lat});
                done = 1;
            end else if (++t > 100) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int base;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = 3'b000;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_zero", {31'b0, out_zero}, 32'h1);
        chk("rst_out_err", {31'b0, out_err}, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed single ops, latency checked
        send(3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1); drain();
        send(3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1); drain();
        send(3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1); drain();
        send(3'b100, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 1); drain();
        send(3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1); drain();
        send(3'b000, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b0, 1); drain();
        send(3'b111, 32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1, 1);
        send(3'b001, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1); drain();
        send(3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1);
        send(3'b010, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 1);
        send(3'b011, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1);
        send(3'b100, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0, 1);
        send(3'b101, 32'hA5A5_A5A5, 5'd3,  32'hA5A5_A5A5, 1'b1, 1);
        send(3'b011, 32'hF000_0000, 5'd16, 32'h0000_F000, 1'b0, 1);
        drain();

        // Six back-to-back ops, consumer stalls 3 cycles after the 2nd result
        base = rx_count;
        fork
            begin
                send(3'b000, 32'h0000_0001, 5'd1, 32'h0000_0002, 1'b0, 0);
                send(3'b001, 32'h0000_00F0, 5'd4, 32'h0000_000F, 1'b0, 0);
                send(3'b011, 32'hF000_0000, 5'd4, 32'h0000_000F, 1'b0, 0);
                send(3'b100, 32'h0000_000F, 5'd4, 32'hF000_0000, 1'b0, 0);
                send(3'b010, 32'h4000_0000, 5'd2, 32'h1000_0000, 1'b0, 0);
                send(3'b000, 32'h0000_0003, 5'd8, 32'h0000_0300, 1'b0, 0);
            end
            begin
                int t = 0;
                while (rx_count < base + 2 && t < 200) begin
                    @(posedge clock);
                    t++;
                end
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
                    chk("stall_out_valid", {31'b0, out_valid}, 32'h1);
                    @(posedge clock);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", rx_count - base, 6);

        // Reset with three ops in flight
        send(3'b000, 32'h0000_0001, 5'd2, 32'h0000_0004, 1'b0, 0);
        send(3'b000, 32'h0000_0001, 5'd3, 32'h0000_0008, 1'b0, 0);
        send(3'b000, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b0, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'h1);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("mid_rst_out_data", out_data, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        send(3'b001, 32'hDEAD_BEEF, 5'd8, 32'h00DE_ADBE, 1'b0, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
